// File: rtl/obi_copy_master.sv
// OBI initiator that copies len_i 32-bit words from src_addr_i to dst_addr_i.
// Each word is one read transaction followed by one write transaction, with
// at most one transaction outstanding at any time.
module obi_copy_master #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned LEN_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic [ADDR_WIDTH-1:0] src_addr_i,
   input  logic [ADDR_WIDTH-1:0] dst_addr_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  obi_req_o,
   input  logic                  obi_gnt_i,
   output logic [ADDR_WIDTH-1:0] obi_addr_o,
   output logic                  obi_we_o,
   output logic [3:0]            obi_be_o,
   output logic [31:0]           obi_wdata_o,
   input  logic                  obi_rvalid_i,
   input  logic [31:0]           obi_rdata_i
);

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdWait,
      StWrReq,
      StWrWait,
      StFinish
   } state_e;

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] src_q, src_d;
   logic [ADDR_WIDTH-1:0] dst_q, dst_d;
   logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
   logic [31:0]           buf_q, buf_d;

   // Full words only.
   assign obi_be_o = 4'hF;

   // State, pointers, remaining word count and data buffer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         src_q   <= '0;
         dst_q   <= '0;
         cnt_q   <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   // Next-state and Moore outputs; outputs depend on state only, so req falls
   // as soon as the state register is reset.
   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      cnt_d       = cnt_q;
      buf_d       = buf_q;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      obi_req_o   = 1'b0;
      obi_we_o    = 1'b0;
      obi_addr_o  = '0;
      obi_wdata_o = '0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (len_i != '0) begin
                  src_d   = {src_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  dst_d   = {dst_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  cnt_d   = len_i;
                  state_d = StRdReq;
               end else begin
                  state_d = StFinish;
               end
            end
         end
         StRdReq: begin
            busy_o     = 1'b1;
            obi_req_o  = 1'b1;
            obi_addr_o = src_q;
            if (obi_gnt_i) state_d = StRdWait;
         end
         StRdWait: begin
            busy_o = 1'b1;
            if (obi_rvalid_i) begin
               buf_d   = obi_rdata_i;
               state_d = StWrReq;
            end
         end
         StWrReq: begin
            busy_o      = 1'b1;
            obi_req_o   = 1'b1;
            obi_we_o    = 1'b1;
            obi_addr_o  = dst_q;
            obi_wdata_o = buf_q;
            if (obi_gnt_i) state_d = StWrWait;
         end
         StWrWait: begin
            busy_o = 1'b1;
            if (obi_rvalid_i) begin
               // Pointers wrap naturally at 2^ADDR_WIDTH.
               src_d   = src_q + ADDR_WIDTH'(4);
               dst_d   = dst_q + ADDR_WIDTH'(4);
               cnt_d   = cnt_q - LEN_WIDTH'(1);
               state_d = (cnt_q == LEN_WIDTH'(1)) ? StFinish : StRdReq;
            end
         end
         StFinish: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

endmodule

// File: tb/tb_obi_copy_master.sv
// Directed bench for obi_copy_master with a behavioural OBI memory responder.
module tb_obi_copy_master;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        start;
   logic [31:0] src, dst;
   logic [15:0] len;
   logic        busy, done;
   logic        obi_req, obi_gnt, obi_we, obi_rvalid;
   logic [31:0] obi_addr, obi_wdata, obi_rdata;
   logic [3:0]  obi_be;

   obi_copy_master #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_ni),
      .start_i     (start),
      .src_addr_i  (src),
      .dst_addr_i  (dst),
      .len_i       (len),
      .busy_o      (busy),
      .done_o      (done),
      .obi_req_o   (obi_req),
      .obi_gnt_i   (obi_gnt),
      .obi_addr_o  (obi_addr),
      .obi_we_o    (obi_we),
      .obi_be_o    (obi_be),
      .obi_wdata_o (obi_wdata),
      .obi_rvalid_i(obi_rvalid),
      .obi_rdata_i (obi_rdata)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory contents; untouched words read back as a fixed address pattern.
   logic [31:0] mem [logic [31:0]];
   logic [31:0] rd_log[$];
   logic [31:0] wr_log[$];

   function automatic logic [31:0] mem_init(input logic [31:0] a);
      return 32'h0000_00A0 + (a >> 2);
   endfunction

   function automatic logic [31:0] mem_peek(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   // Responder knobs (owned by the main sequence).
   int unsigned stall_max = 0;
   int unsigned dly_max   = 1;
   int unsigned stale_req = 0;

   // Responder/monitor counters (owned by the responder).
   int unsigned n_rd = 0, n_wr = 0, n_done = 0, n_busy = 0, n_req = 0;
   int unsigned stab_err = 0, ovl_err = 0, c_done = 0;

   // OBI responder and monitor, evaluated on the falling edge.
   initial begin : responder
      logic        pending, in_req, req_prev, g_last, acc_we;
      logic [31:0] sv_addr, sv_wdata, rd_val;
      logic        sv_we;
      int unsigned rv_cnt, stall_left, stale_ack;
      pending = 0; in_req = 0; req_prev = 0; acc_we = 0; sv_we = 0;
      sv_addr = 0; sv_wdata = 0; rd_val = 0; rv_cnt = 0; stall_left = 0; stale_ack = 0;
      obi_gnt = 0; obi_rvalid = 0; obi_rdata = 0;
      forever begin
         @(negedge clk);
         if (!rst_ni) begin
            obi_gnt = 0; obi_rvalid = 0; obi_rdata = 0;
            pending = 0; in_req = 0; req_prev = 0; rv_cnt = 0;
         end else begin
            if (done) begin n_done++; c_done = cyc; end
            if (busy) n_busy++;
            if (obi_req) n_req++;
            g_last = obi_gnt;
            if (obi_rvalid) begin
               obi_rvalid = 0; obi_rdata = 0; pending = 0;
            end
            if (obi_gnt && req_prev) begin
               acc_we = sv_we;
               if (sv_we) begin
                  mem[sv_addr] = sv_wdata; n_wr++; wr_log.push_back(sv_addr);
               end else begin
                  rd_val = mem.exists(sv_addr) ? mem[sv_addr] : mem_init(sv_addr);
                  n_rd++; rd_log.push_back(sv_addr);
               end
               pending = 1; in_req = 0;
               rv_cnt = $urandom_range(dly_max, 1);
            end
            obi_gnt = 0;
            if (pending && rv_cnt > 0) begin
               rv_cnt--;
               if (rv_cnt == 0) begin
                  obi_rvalid = 1;
                  obi_rdata  = acc_we ? 32'hBAD0_0BAD : rd_val;
               end
            end else if (stale_req != stale_ack) begin
               stale_ack  = stale_req;
               obi_rvalid = 1;
               obi_rdata  = 32'hDEAD_BEEF;
            end
            if (pending && obi_req) ovl_err++;
            if (obi_req && req_prev && !g_last &&
                (obi_addr !== sv_addr || obi_we !== sv_we || obi_wdata !== sv_wdata))
               stab_err++;
            if (obi_req && !pending) begin
               if (!in_req) begin
                  in_req = 1;
                  stall_left = (stall_max == 0) ? 0 : $urandom_range(stall_max, 0);
               end
               if (stall_left == 0) obi_gnt = 1;
               else stall_left--;
            end
            req_prev = obi_req; sv_addr = obi_addr; sv_we = obi_we; sv_wdata = obi_wdata;
         end
      end
   end

   int unsigned total = 0, bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   int unsigned s_rd, s_wr, s_done, s_busy, s_req, s_stab, s_ovl, s_rdq, s_wrq, c0;

   task automatic snap();
      s_rd = n_rd; s_wr = n_wr; s_done = n_done; s_busy = n_busy; s_req = n_req;
      s_stab = stab_err; s_ovl = ovl_err; s_rdq = rd_log.size(); s_wrq = wr_log.size();
   endtask

   function automatic logic [31:0] rd_at(input int unsigned i);
      return (s_rdq + i < rd_log.size()) ? rd_log[s_rdq + i] : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] wr_at(input int unsigned i);
      return (s_wrq + i < wr_log.size()) ? wr_log[s_wrq + i] : 32'hFFFF_FFFF;
   endfunction

   task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
      @(negedge clk); #1;
      snap();
      src = s; dst = d; len = l; start = 1; c0 = cyc;
      @(negedge clk);
      start = 0;
   endtask

   task automatic wait_done(input int unsigned limit, output bit ok);
      ok = 0;
      for (int i = 0; i < limit && !ok; i++) begin
         @(negedge clk); #1;
         if (n_done != s_done) ok = 1;
      end
   endtask

   task automatic idle(input int unsigned n);
      for (int i = 0; i < n; i++) @(negedge clk);
      #1;
   endtask

   bit ok;

   initial begin
      rst_ni = 0; start = 0; src = 0; dst = 0; len = 0;

      // Reset values.
      idle(3);
      check("rst_req", {31'b0, obi_req}, 32'd0);
      check("rst_we", {31'b0, obi_we}, 32'd0);
      check("rst_addr", obi_addr, 32'h0);
      check("rst_wdata", obi_wdata, 32'h0);
      check("rst_be", {28'b0, obi_be}, 32'hF);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      rst_ni = 1;
      snap();
      idle(10);
      check("idle_req_cycles", n_req - s_req, 0);
      check("idle_busy_cycles", n_busy - s_busy, 0);

      // Basic 4-word copy, zero wait states.
      start_copy(32'h0, 32'h100, 16'd4);
      wait_done(200, ok);
      check("basic_done_seen", {31'b0, ok}, 32'd1);
      check("basic_latency", c_done - c0, 17);
      idle(3);
      check("basic_done_cnt", n_done - s_done, 1);
      check("basic_busy_cycles", n_busy - s_busy, 16);
      check("basic_w0", mem_peek(32'h100), 32'hA0);
      check("basic_w1", mem_peek(32'h104), 32'hA1);
      check("basic_w2", mem_peek(32'h108), 32'hA2);
      check("basic_w3", mem_peek(32'h10C), 32'hA3);

      // Zero-length copy.
      start_copy(32'h40, 32'h900, 16'd0);
      wait_done(20, ok);
      check("len0_done_seen", {31'b0, ok}, 32'd1);
      check("len0_latency", c_done - c0, 1);
      idle(3);
      check("len0_done_cnt", n_done - s_done, 1);
      check("len0_req_cycles", n_req - s_req, 0);
      check("len0_busy_cycles", n_busy - s_busy, 0);

      // Random grant stalls and response delays.
      stall_max = 5; dly_max = 3;
      start_copy(32'h400, 32'h800, 16'd8);
      wait_done(1000, ok);
      check("stall_done_seen", {31'b0, ok}, 32'd1);
      idle(3);
      stall_max = 0; dly_max = 1;
      for (int i = 0; i < 8; i++)
         check($sformatf("stall_w%0d", i), mem_peek(32'h800 + 4 * i), 32'h1A0 + i);
      check("stall_stability", stab_err - s_stab, 0);
      check("stall_outstanding", ovl_err - s_ovl, 0);
      check("stall_reads", n_rd - s_rd, 8);
      check("stall_writes", n_wr - s_wr, 8);
      check("stall_done_cnt", n_done - s_done, 1);

      // Unaligned addresses are truncated to word boundaries.
      start_copy(32'h13, 32'h7F, 16'd2);
      wait_done(200, ok);
      check("unal_done_seen", {31'b0, ok}, 32'd1);
      idle(2);
      check("unal_rd0", rd_at(0), 32'h10);
      check("unal_rd1", rd_at(1), 32'h14);
      check("unal_wr0", wr_at(0), 32'h7C);
      check("unal_wr1", wr_at(1), 32'h80);
      check("unal_d0", mem_peek(32'h7C), 32'hA4);
      check("unal_d1", mem_peek(32'h80), 32'hA5);

      // Source pointer wraps to zero.
      start_copy(32'hFFFF_FFFC, 32'h200, 16'd2);
      wait_done(200, ok);
      check("wrap_done_seen", {31'b0, ok}, 32'd1);
      idle(2);
      check("wrap_rd0", rd_at(0), 32'hFFFF_FFFC);
      check("wrap_rd1", rd_at(1), 32'h0);
      check("wrap_d0", mem_peek(32'h200), 32'h4000_009F);
      check("wrap_d1", mem_peek(32'h204), 32'hA0);

      // start held high while busy must be ignored.
      start_copy(32'h20, 32'h300, 16'd3);
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         start = busy;
         #1;
         if (n_done != s_done) ok = 1;
      end
      start = 0;
      check("hold_done_seen", {31'b0, ok}, 32'd1);
      idle(5);
      check("hold_reads", n_rd - s_rd, 3);
      check("hold_writes", n_wr - s_wr, 3);
      check("hold_done_cnt", n_done - s_done, 1);
      check("hold_d2", mem_peek(32'h308), 32'hAA);

      // Reset while waiting for the response of word 2 of 5.
      start_copy(32'h40, 32'h600, 16'd5);
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk); #1;
         if (n_wr - s_wr == 2) ok = 1;
      end
      check("abort_reached", {31'b0, ok}, 32'd1);
      rst_ni = 0;
      #1;
      check("abort_req", {31'b0, obi_req}, 32'd0);
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_done", {31'b0, done}, 32'd0);
      idle(3);
      @(negedge clk);
      rst_ni = 1;
      #1;
      check("abort_no_done", n_done - s_done, 0);
      snap();
      stale_req++;
      idle(4);
      check("stale_no_req", n_req - s_req, 0);
      check("stale_no_busy", n_busy - s_busy, 0);
      start_copy(32'h60, 32'h500, 16'd1);
      wait_done(100, ok);
      check("after_done_seen", {31'b0, ok}, 32'd1);
      idle(3);
      check("after_d0", mem_peek(32'h500), 32'hB8);
      check("after_reads", n_rd - s_rd, 1);
      check("after_writes", n_wr - s_wr, 1);
      check("after_done_cnt", n_done - s_done, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/obi_copy_master.md
Name: obi_copy_master

Overview:
OBI initiator that copies a block of 32-bit words from a source address to a destination address, one word at a time. It drives one OBI port of the double-port SRAM, or any OBI responder. The core programs it with start/src/dst/len and observes busy/done. It is the initiating end of the OBI protocol that the SRAM wrappers serve.

Parameters:
ADDR_WIDTH, 32, OBI address width in bits
LEN_WIDTH, 16, width of the word-count input and internal counter

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  one-cycle start pulse, sampled only in IDLE
src_addr_i  input  ADDR_WIDTH  source byte address; bits [1:0] ignored
dst_addr_i  input  ADDR_WIDTH  destination byte address; bits [1:0] ignored
len_i  input  LEN_WIDTH  number of 32-bit words to copy
busy_o  output  1  high from the cycle after an accepted start until done
done_o  output  1  one-cycle pulse when the copy completes
obi_req_o  output  1  OBI request
obi_gnt_i  input  1  OBI grant
obi_addr_o  output  ADDR_WIDTH  OBI address, always word-aligned
obi_we_o  output  1  1 = write, 0 = read
obi_be_o  output  4  byte enables; always 4'hF
obi_wdata_o  output  32  write data
obi_rvalid_i  input  1  response valid, for both reads and writes
obi_rdata_i  input  32  read data

Behaviour:
- Reset values: all outputs 0, except obi_be_o = 4'hF. FSM in IDLE. Internal address registers, counter and data buffer are cleared.
- Reset asserted mid-copy aborts immediately: req drops asynchronously, no done pulse. Responses still in flight after reset release are ignored while in IDLE.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, FINISH.
- IDLE:
  - On start_i with len_i != 0: latch {src[AW-1:2],2'b00}, {dst[AW-1:2],2'b00} and len_i, then go to RD_REQ.
  - On start_i with len_i == 0: go to FINISH. No OBI traffic.
  - start_i in any other state is ignored.
- RD_REQ: req=1, we=0, addr=src pointer. When gnt=1, go to RD_WAIT. In the gnt cycle req is still 1; it is 0 from the next cycle.
- RD_WAIT: req=0. When rvalid=1, capture rdata into the data buffer and go to WR_REQ.
- WR_REQ: req=1, we=1, addr=dst pointer, wdata=buffer. When gnt=1, go to WR_WAIT.
- WR_WAIT: req=0. When rvalid=1 (rdata ignored):
  - src += 4, dst += 4, count -= 1.
  - If count reaches 0, go to FINISH; otherwise go to RD_REQ.
- FINISH: done_o=1 for exactly one cycle, busy_o=0 in that cycle, then return to IDLE.
- OBI rules:
  - While req=1 and gnt=0, addr, we, be and wdata are held stable.
  - At most one transaction is outstanding; a new req is never raised before the previous rvalid.
  - Gnt may arrive in the same cycle req rises (zero wait).
  - rvalid arrives at least 1 cycle after gnt. rvalid outside RD_WAIT/WR_WAIT is ignored.
- Timing: each word takes a minimum of 4 cycles with zero-wait gnt and 1-cycle rvalid. Minimum total is 4*len+1 cycles from the start cycle to the done pulse.
- busy_o is 1 in every state except IDLE and FINISH.
- Arithmetic:
  - Pointers wrap modulo 2^ADDR_WIDTH; no error is flagged.
  - len_i = 2^LEN_WIDTH-1 is legal.
  - src == dst is legal (word rewritten with itself).
  - Overlapping regions copy strictly in ascending address order with no special handling.

Test Plan:
- Reset, then idle: all outputs 0, be=4'hF, no req for 10 cycles. Then start with src=0x0, dst=0x100, len=4, SRAM preloaded 0xA0..0xA3: dst words 0x100..0x10C = 0xA0..0xA3, exactly one done pulse, busy high for 16 cycles with zero wait states.
- len=0 start: done pulses the cycle after start, obi_req_o never asserts, busy stays 0.
- Responder inserts random 0-5 cycle gnt stalls and 1-3 cycle rvalid delays, len=8: addr/we/wdata stable throughout each stall, copy correct, never more than one outstanding transaction.
- src=0x13, dst=0x7F, len=2: OBI addresses are 0x10, 0x14 (reads) and 0x7C, 0x80 (writes). Pointer wrap case: src=0xFFFFFFFC, len=2: second read address is 0x00000000.
- start_i pulsed every cycle while busy (len=3): ignored, exactly 3 reads + 3 writes, single done.
- rst_ni asserted during WR_WAIT of word 2 of 5: req drops immediately, no done. After release, a new start with len=1 completes correctly even with a stale rvalid injected during IDLE.
